// File: rtl/timer0_pkg.sv
// Shared definitions for the timer0 block: prescale select codes, FSM states
// and the select-to-ratio mapping.
package timer0_pkg;

   localparam int SEL_W   = 3;
   localparam int RATIO_W = 9;
   localparam int PCNT_W  = 8;

   localparam logic [SEL_W-1:0] SEL_STOP   = 3'd0;
   localparam logic [SEL_W-1:0] SEL_DIV1   = 3'd1;
   localparam logic [SEL_W-1:0] SEL_DIV4   = 3'd2;
   localparam logic [SEL_W-1:0] SEL_DIV8   = 3'd3;
   localparam logic [SEL_W-1:0] SEL_DIV64  = 3'd4;
   localparam logic [SEL_W-1:0] SEL_DIV256 = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN
   } state_e;

   // Zero means stopped or reserved; any non-zero value is a usable ratio.
   function automatic logic [RATIO_W-1:0] presc_ratio(input logic [SEL_W-1:0] sel);
      case (sel)
         SEL_DIV1:   return 9'd1;
         SEL_DIV4:   return 9'd4;
         SEL_DIV8:   return 9'd8;
         SEL_DIV64:  return 9'd64;
         SEL_DIV256: return 9'd256;
         default:    return 9'd0;
      endcase
   endfunction

endpackage

// File: rtl/timer0_if.sv
// Control/status bundle between the timer0 register front end and timer0_ctrl.
interface timer0_if
   import timer0_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic             start;
   logic             stop;
   logic [SEL_W-1:0] clk_sel;
   logic             mode;
   logic [WIDTH-1:0] ocr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [1:0]       flag_clr;
   logic [WIDTH-1:0] tcnt;
   logic             tick;
   logic             ovf_flag;
   logic             cmp_flag;
   logic             running;

   modport master (
      output start, stop, clk_sel, mode, ocr, load, load_val, flag_clr,
      input  tcnt, tick, ovf_flag, cmp_flag, running
   );

   modport slave (
      input  start, stop, clk_sel, mode, ocr, load, load_val, flag_clr,
      output tcnt, tick, ovf_flag, cmp_flag, running
   );
endinterface

// File: rtl/timer0_prescaler.sv
// Prescale counter: counts 0..ratio-1 while enabled and flags the last step
// as a single-cycle tick.
module timer0_prescaler
   import timer0_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               clr,
   input  logic [RATIO_W-1:0] ratio,
   output logic               tick
);
   logic [PCNT_W-1:0] pcnt_reg;
   logic [PCNT_W-1:0] pcnt_next;
   logic              at_end;

   assign at_end = (ratio != '0) && ({1'b0, pcnt_reg} == ratio - RATIO_W'(1));
   assign tick   = en && at_end;

   // Clear beats counting so a load or ratio switch restarts the period.
   always_comb begin
      pcnt_next = pcnt_reg;
      if (clr)
         pcnt_next = '0;
      else if (en && ratio != '0)
         pcnt_next = at_end ? '0 : pcnt_reg + PCNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pcnt_reg <= '0;
      else
         pcnt_reg <= pcnt_next;
   end
endmodule

// File: rtl/timer0_ctrl.sv
// timer0 sequencing: IDLE/ARM/RUN FSM, prescaled count update in normal or
// CTC mode, and sticky overflow/compare flags.
module timer0_ctrl
   import timer0_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input logic     clk,
   input logic     rst_n,
   timer0_if.slave bus
);
   localparam logic [WIDTH-1:0] TCNT_MAX = '1;

   state_e             state_reg;
   logic               running_reg;
   logic [SEL_W-1:0]   sel_prev_reg;
   logic [WIDTH-1:0]   tcnt_reg;
   logic [WIDTH-1:0]   tcnt_next;
   logic [1:0]         flag_set;
   logic [1:0]         flags;
   logic [RATIO_W-1:0] ratio;
   logic               sel_valid;
   logic               sel_chg;
   logic               in_run;
   logic               tick;

   assign ratio     = presc_ratio(bus.clk_sel);
   assign sel_valid = (ratio != '0);
   assign in_run    = (state_reg == ST_RUN);
   // A switch to another valid ratio mid-run restarts the prescaler and eats that cycle's tick.
   assign sel_chg   = in_run && sel_valid && (bus.clk_sel != sel_prev_reg);

   timer0_prescaler u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_run && !sel_chg),
      .clr   ((state_reg == ST_ARM) || sel_chg || bus.load),
      .ratio (ratio),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         running_reg  <= 1'b0;
         sel_prev_reg <= '0;
      end else begin
         sel_prev_reg <= bus.clk_sel;
         case (state_reg)
            ST_IDLE: begin
               if (bus.start && !bus.stop && sel_valid)
                  state_reg <= ST_ARM;
            end
            ST_ARM: begin
               state_reg   <= ST_RUN;
               running_reg <= 1'b1;
            end
            ST_RUN: begin
               if (bus.stop || !sel_valid) begin
                  state_reg   <= ST_IDLE;
                  running_reg <= 1'b0;
               end
            end
            default: begin
               state_reg   <= ST_IDLE;
               running_reg <= 1'b0;
            end
         endcase
      end
   end

   // flag_set[0] = overflow, flag_set[1] = compare; a load suppresses both.
   always_comb begin
      tcnt_next = tcnt_reg;
      flag_set  = '0;
      if (bus.load) begin
         tcnt_next = bus.load_val;
      end else if (tick) begin
         if (bus.mode && tcnt_reg == bus.ocr) begin
            tcnt_next   = '0;
            flag_set[1] = 1'b1;
         end else begin
            tcnt_next   = tcnt_reg + WIDTH'(1);
            flag_set[0] = (tcnt_reg == TCNT_MAX);
            flag_set[1] = (tcnt_reg == bus.ocr);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tcnt_reg <= '0;
      else
         tcnt_reg <= tcnt_next;
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_flag
      logic flag_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            flag_reg <= 1'b0;
         else
            flag_reg <= flag_set[gi] | (flag_reg & ~bus.flag_clr[gi]);
      end
      assign flags[gi] = flag_reg;
   end

   assign bus.tcnt     = tcnt_reg;
   assign bus.tick     = tick;
   assign bus.ovf_flag = flags[0];
   assign bus.cmp_flag = flags[1];
   assign bus.running  = running_reg;
endmodule
